// File: rtl/div241_digit_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : div241_digit_seq
// Purpose  : Digit-serial sequencer for constant division by 241. Walks a
//            dividend MSB-first one radix-16 digit at a time, drives an
//            external quotient/remainder lookup slice and accumulates the
//            returned quotient digits.
// Options  : DIV241_SKIP_LZ_EN - skip leading zero digits of the dividend.
// Revision : 1.0 - initial release
// ============================================================================
module div241_digit_seq #(
  parameter int DIVIDEND_W = 60,
  parameter int DIGIT_W    = 4,
  parameter int REM_W      = 8,
  parameter int DIVISOR    = 241,
  parameter int LUT_LAT    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DIVIDEND_W-1:0]    in_dividend,
  output logic [REM_W+DIGIT_W-1:0] lut_addr,
  output logic                     lut_req,
  input  logic [DIGIT_W-1:0]       lut_qdig,
  input  logic [REM_W-1:0]         lut_rem,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DIVIDEND_W-1:0]    out_quot,
  output logic [REM_W-1:0]         out_rem,
  output logic                     out_err
);

  localparam int             c_NDIG    = DIVIDEND_W / DIGIT_W;
  localparam int             c_IDX_W   = (c_NDIG > 1) ? $clog2(c_NDIG) : 1;
  localparam logic [REM_W:0] c_DIVISOR = (REM_W+1)'(DIVISOR);
  localparam logic [1:0]     c_LAT     = 2'(LUT_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DIVIDEND_W-1:0]   r_dividend;
  logic [DIVIDEND_W-1:0]   r_quot;
  logic [REM_W-1:0]        r_rem;
  logic [c_IDX_W-1:0]      r_idx;
  logic [1:0]              r_wcnt;
  logic                    r_err;
  logic [DIVIDEND_W-1:0]   r_out_quot;
  logic [REM_W-1:0]        r_out_rem;
  logic                    r_out_err;

  logic [c_IDX_W-1:0]      w_idx_eff;
  logic [DIGIT_W-1:0]      w_digit;
  logic                    w_last;
  logic                    w_capture;
  logic                    w_zero_skip;
  logic                    w_rem_oor;

`ifdef DIV241_SKIP_LZ_EN
  // Set on accept; marks the first ISSUE cycle where the start digit is chosen.
  logic                    r_first;
  logic [c_IDX_W-1:0]      w_msd;

  // Priority encoder: index of the most-significant nonzero digit.
  always_comb begin
    w_msd = '0;
    for (int i = 0; i < c_NDIG; i++) begin
      if (r_dividend[i*DIGIT_W +: DIGIT_W] != '0) w_msd = c_IDX_W'(i);
    end
  end

  assign w_idx_eff   = r_first ? w_msd : r_idx;
  assign w_zero_skip = r_first && (r_dividend == '0);
`else
  assign w_idx_eff   = r_idx;
  assign w_zero_skip = 1'b0;
`endif

  assign w_digit   = r_dividend[w_idx_eff*DIGIT_W +: DIGIT_W];
  assign w_last    = (w_idx_eff == '0);
  assign w_rem_oor = ({1'b0, lut_rem} >= c_DIVISOR);

  // Address comes straight from registers so it is stable across WAIT.
  assign lut_addr  = {r_rem, w_digit};
  assign out_valid = (r_state == S_DONE);
  assign out_quot  = r_out_quot;
  assign out_rem   = r_out_rem;
  assign out_err   = r_out_err;

  // State register; async reset also drops lut_req since it decodes the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, handshake and lookup strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    lut_req     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_zero_skip) begin
          w_state_nxt = S_DONE;
        end else begin
          lut_req = 1'b1;
          if (LUT_LAT == 0) begin
            w_capture   = 1'b1;
            w_state_nxt = w_last ? S_DONE : S_ISSUE;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_wcnt == 2'd1) begin
          w_capture   = 1'b1;
          w_state_nxt = w_last ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand latch, digit walk, quotient accumulation, result regs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dividend <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_idx      <= '0;
      r_wcnt     <= '0;
      r_err      <= 1'b0;
      r_out_quot <= '0;
      r_out_rem  <= '0;
      r_out_err  <= 1'b0;
`ifdef DIV241_SKIP_LZ_EN
      r_first    <= 1'b0;
`endif
    end else begin
      if ((r_state == S_IDLE) && in_valid) begin
        r_dividend <= in_dividend;
        r_rem      <= '0;
        r_idx      <= c_IDX_W'(c_NDIG - 1);
        r_quot     <= '0;
        r_err      <= 1'b0;
`ifdef DIV241_SKIP_LZ_EN
        r_first    <= 1'b1;
`endif
      end
      if (r_state == S_ISSUE) begin
        // Freeze the effective start index so WAIT keeps the same digit.
        r_idx  <= w_idx_eff;
        r_wcnt <= c_LAT;
`ifdef DIV241_SKIP_LZ_EN
        r_first <= 1'b0;
`endif
        if (w_zero_skip) begin
          r_out_quot <= '0;
          r_out_rem  <= '0;
          r_out_err  <= 1'b0;
        end
      end
      if (r_state == S_WAIT) r_wcnt <= r_wcnt - 2'd1;
      if (w_capture) begin
        r_quot <= {r_quot[DIVIDEND_W-DIGIT_W-1:0], lut_qdig};
        r_rem  <= lut_rem;
        r_err  <= r_err | w_rem_oor;
        if (w_last) begin
          r_out_quot <= {r_quot[DIVIDEND_W-DIGIT_W-1:0], lut_qdig};
          r_out_rem  <= lut_rem;
          r_out_err  <= r_err | w_rem_oor;
        end else begin
          r_idx <= w_idx_eff - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div241_digit_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_div241_digit_seq
// Purpose  : Directed and random checks of div241_digit_seq with a golden
//            lookup slice; instance 0 uses LUT_LAT=0, instance 1 LUT_LAT=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div241_digit_seq;

  logic        clk;
  logic        rst;
  logic [1:0]  in_valid, in_ready, lut_req, out_valid, out_ready, out_err;
  logic [59:0] in_div   [2];
  logic [59:0] out_quot [2];
  logic [11:0] lut_addr [2];
  logic [3:0]  lut_qdig [2];
  logic [7:0]  lut_rem  [2];
  logic [7:0]  out_rem  [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit inj   = 1'b0;
  int reqcnt;

  typedef struct {
    logic [59:0] div;
    logic [59:0] quot;
    logic [7:0]  rem;
    int          sel;
  } vec_t;
  vec_t vecs [10];

  div241_digit_seq #(.LUT_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_dividend(in_div[0]),
    .lut_addr(lut_addr[0]), .lut_req(lut_req[0]),
    .lut_qdig(lut_qdig[0]), .lut_rem(lut_rem[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_quot(out_quot[0]), .out_rem(out_rem[0]), .out_err(out_err[0])
  );

  div241_digit_seq #(.LUT_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_dividend(in_div[1]),
    .lut_addr(lut_addr[1]), .lut_req(lut_req[1]),
    .lut_qdig(lut_qdig[1]), .lut_rem(lut_rem[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_quot(out_quot[1]), .out_rem(out_rem[1]), .out_err(out_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden slice: {rem, digit} / 241. Optional fault on step 5 of instance 0.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      lut_qdig[s] = 4'(lut_addr[s] / 241);
      lut_rem[s]  = 8'(lut_addr[s] % 241);
    end
    if (inj && lut_req[0] && (reqcnt == 4)) lut_rem[0] = 8'd250;
  end

  // Lookup requests since the last accept on instance 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           reqcnt <= 0;
    else if (in_valid[0] && in_ready[0]) reqcnt <= 0;
    else if (lut_req[0])               reqcnt <= reqcnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [59:0] d, input int lat);
`ifdef DIV241_SKIP_LZ_EN
    int n;
    n = 0;
    for (int i = 0; i < 15; i++) if (d[i*4 +: 4] != 4'd0) n = i + 1;
    return (n == 0) ? 1 : n * (lat + 1);
`else
    return 15 * (lat + 1);
`endif
  endfunction

  // Instance 1: address must hold and the strobe stay low through both WAIT cycles.
  initial begin
    int hold;
    logic [11:0] haddr;
    hold = 0;
    haddr = '0;
    forever begin
      @(negedge clk);
      if (rst) hold = 0;
      else if (hold > 0) begin
        chk("wait_addr_stable", 64'(lut_addr[1]), 64'(haddr));
        chk("wait_req_low", 64'(lut_req[1]), 64'd0);
        hold--;
      end else if (lut_req[1]) begin
        haddr = lut_addr[1];
        hold  = 2;
      end
    end
  end

  task automatic send(input int s, input logic [59:0] d);
    int k;
    k = 0;
    @(negedge clk);
    in_div[s]   = d;
    in_valid[s] = 1'b1;
    while (!in_ready[s] && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", 64'(in_ready[s]), 64'd1);
    @(posedge clk);
    #1 in_valid[s] = 1'b0;
  endtask

  task automatic wait_valid(input int s, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid[s] && lat < 300);
    chk("valid_seen", 64'(out_valid[s]), 64'd1);
  endtask

  task automatic handshake(input int s);
    @(negedge clk);
    out_ready[s] = 1'b1;
    @(posedge clk);
    #1 out_ready[s] = 1'b0;
  endtask

  task automatic run_one(input int s, input logic [59:0] d, output logic [59:0] q,
                         output logic [7:0] r, output logic e, output int lat);
    send(s, d);
    wait_valid(s, lat);
    q = out_quot[s];
    r = out_rem[s];
    e = out_err[s];
    handshake(s);
  endtask

  task automatic run_random(input int s, input int n);
    logic [59:0] q [$];
    logic [59:0] d;
    logic [63:0] t;
    int sent, rcv, dc, mc;
    bit acc;
    sent = 0; rcv = 0; dc = 0; mc = 0; acc = 1'b0;
    fork
      begin
        while (sent < n && dc < n * 300) begin
          @(negedge clk);
          dc++;
          if (acc) begin
            in_valid[s] = 1'b0;
            acc = 1'b0;
          end
          if (!in_valid[s] && ($urandom_range(0, 3) != 0)) begin
            t = {$urandom, $urandom};
            in_div[s]   = t[59:0] >> $urandom_range(0, 60);
            in_valid[s] = 1'b1;
          end
          if (in_valid[s] && in_ready[s]) begin
            q.push_back(in_div[s]);
            sent++;
            acc = 1'b1;
          end
        end
        @(negedge clk);
        in_valid[s] = 1'b0;
      end
      begin
        while (rcv < n && mc < n * 300) begin
          @(negedge clk);
          mc++;
          out_ready[s] = ($urandom_range(0, 2) != 0);
          if (out_valid[s] && out_ready[s]) begin
            if (q.size() == 0) chk("rand_extra", 64'd1, 64'd0);
            else begin
              d = q.pop_front();
              chk("rand_quot", 64'(out_quot[s]), 64'(d / 60'd241));
              chk("rand_rem",  64'(out_rem[s]),  64'(d % 60'd241));
              chk("rand_err",  64'(out_err[s]),  64'd0);
            end
            rcv++;
          end
        end
        out_ready[s] = 1'b0;
      end
    join
    chk("rand_count", 64'(rcv), 64'(n));
    chk("rand_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [59:0] q;
    logic [7:0]  r;
    logic        e;
    int          lat, bad;

    vecs[0] = '{60'd1000,                     60'd4,                 8'd36,  0};
    vecs[1] = '{60'hFFF_FFFF_FFFF_FFFF,        60'd4783906658119696,  8'd239, 1};
    vecs[2] = '{60'd241,                      60'd1,                 8'd0,   0};
    vecs[3] = '{60'd0,                        60'd0,                 8'd0,   0};
    vecs[4] = '{60'd240,                      60'd0,                 8'd240, 0};
    vecs[5] = '{60'd482,                      60'd2,                 8'd0,   1};
    vecs[6] = '{60'd241007,                   60'd1000,              8'd7,   1};
    vecs[7] = '{60'd58081,                    60'd241,               8'd0,   0};
    vecs[8] = '{60'd1,                        60'd0,                 8'd1,   1};
    vecs[9] = '{60'hFFF_FFFF_FFFF_FFFF,        60'd4783906658119696,  8'd239, 0};

    rst = 1'b1;
    in_valid = '0;
    out_ready = '0;
    in_div[0] = '0;
    in_div[1] = '0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_in_ready",  64'(in_ready[s]),  64'd1);
      chk("rst_out_valid", 64'(out_valid[s]), 64'd0);
      chk("rst_lut_req",   64'(lut_req[s]),   64'd0);
      chk("rst_lut_addr",  64'(lut_addr[s]),  64'd0);
      chk("rst_out_quot",  64'(out_quot[s]),  64'd0);
      chk("rst_out_rem",   64'(out_rem[s]),   64'd0);
      chk("rst_out_err",   64'(out_err[s]),   64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Table of directed vectors.
    for (int i = 0; i < 10; i++) begin
      run_one(vecs[i].sel, vecs[i].div, q, r, e, lat);
      chk($sformatf("v%0d_quot", i), 64'(q), 64'(vecs[i].quot));
      chk($sformatf("v%0d_rem", i),  64'(r), 64'(vecs[i].rem));
      chk($sformatf("v%0d_err", i),  64'(e), 64'd0);
      chk($sformatf("v%0d_lat", i),  64'(lat),
          64'(exp_lat(vecs[i].div, (vecs[i].sel == 1) ? 2 : 0)));
    end

    // Back-to-back 241 then 0 with the consumer stalled for 10 cycles.
    send(0, 60'd241);
    wait_valid(0, lat);
    chk("b2b_lat1", 64'(lat), 64'(exp_lat(60'd241, 0)));
    @(negedge clk);
    in_div[0]   = '0;
    in_valid[0] = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!out_valid[0] || in_ready[0] || out_quot[0] != 60'd1 || out_rem[0] != 8'd0) bad++;
    end
    chk("b2b_stall_stable", 64'(bad), 64'd0);
    @(negedge clk);
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1 out_ready[0] = 1'b0;
    chk("b2b_idle_ready",  64'(in_ready[0]),  64'd1);
    chk("b2b_valid_low",   64'(out_valid[0]), 64'd0);
    chk("b2b_quot_kept",   64'(out_quot[0]),  64'd1);
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    wait_valid(0, lat);
    chk("b2b_lat2", 64'(lat), 64'(exp_lat(60'd0, 0)));
    chk("b2b_quot2", 64'(out_quot[0]), 64'd0);
    chk("b2b_rem2",  64'(out_rem[0]),  64'd0);
    handshake(0);

    // Out-of-range remainder on step 5, then a clean division.
    inj = 1'b1;
    run_one(0, 60'hFFF_FFFF_FFFF_FFFF, q, r, e, lat);
    chk("inj_err_set", 64'(e), 64'd1);
    inj = 1'b0;
    run_one(0, 60'd1000, q, r, e, lat);
    chk("inj_err_clear", 64'(e), 64'd0);
    chk("inj_next_quot", 64'(q), 64'd4);
    chk("inj_next_rem",  64'(r), 64'd36);

    // Asynchronous reset while step 7 is being issued.
    send(0, 60'hFFF_FFFF_FFFF_FFFF);
    repeat (6) @(posedge clk);
    #3;
    chk("mid_req_before", 64'(lut_req[0]), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_lut_req",   64'(lut_req[0]),   64'd0);
    chk("mid_lut_addr",  64'(lut_addr[0]),  64'd0);
    chk("mid_in_ready",  64'(in_ready[0]),  64'd1);
    chk("mid_out_valid", 64'(out_valid[0]), 64'd0);
    chk("mid_out_quot",  64'(out_quot[0]),  64'd0);
    chk("mid_out_rem",   64'(out_rem[0]),   64'd0);
    chk("mid_out_err",   64'(out_err[0]),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_one(0, 60'd482, q, r, e, lat);
    chk("post_rst_quot", 64'(q), 64'd2);
    chk("post_rst_rem",  64'(r), 64'd0);
    chk("post_rst_lat",  64'(lat), 64'(exp_lat(60'd482, 0)));

    // Random dividends against a division reference with consumer stalls.
    run_random(0, 1000);
    run_random(1, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
